// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipeline output path.
// AF_MARGIN is derived from the pipeline depth so that every in-flight word still has a slot.
package pipeline_pkg;

    localparam int PIPE_DATA_WIDTH = 32;
    localparam int NUM_STAGES      = 4;
    localparam int PIPE_AF_MARGIN  = NUM_STAGES + 1;

    typedef logic [PIPE_DATA_WIDTH-1:0] stream_word_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pipeline_result_fifo_if.sv
// Push stream in from the pipeline and valid/ready stream out to the consumer.
interface pipeline_result_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/pipeline_fifo_mem.sv
// FIFO storage array: one synchronous write port and one asynchronous read port.
// The array has no reset because the pointers alone decide which entries are meaningful.
module pipeline_fifo_mem #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_result_fifo.sv
// Elastic output buffer behind the processing pipeline, with show-ahead read.
// almost_full throttles the pipeline enable; drop and sum statistics are exposed for status.
module pipeline_result_fifo
    import pipeline_pkg::*;
#(
    parameter  int DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter  int DEPTH      = 16,
    parameter  int AF_MARGIN  = PIPE_AF_MARGIN,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    pipeline_result_fifo_if.slave bus,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  full,
    output logic                  overflow,
    output logic [15:0]           drop_count,
    output logic [DATA_WIDTH-1:0] out_sum
);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  out_valid_q;
    occ_state_t            state;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  mem_we;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] head_word;
    logic [DATA_WIDTH-1:0] out_data_c;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop  = out_valid_q && bus.out_ready;
        push = bus.in_valid && (!full || pop);
        drop = bus.in_valid && full && !pop;
        if (clear) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    assign mem_we        = push && !clear;
    assign out_data_c    = out_valid_q ? head_word : '0;
    assign bus.out_data  = out_data_c;
    assign bus.out_valid = out_valid_q;

    pipeline_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            out_sum     <= '0;
            state       <= OCC_EMPTY;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            out_sum     <= '0;
            state       <= OCC_EMPTY;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                out_sum <= out_sum + out_data_c;
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc16(drop_count);
            end
            // Flags come from the next occupancy so they line up with count.
            count       <= count_next;
            out_valid_q <= (count_next != '0);
            full        <= (count_next == CW'(DEPTH));
            almost_full <= (count_next >= CW'(DEPTH - AF_MARGIN));
            case (state)
                OCC_EMPTY: begin
                    if (push) state <= OCC_PARTIAL;
                end
                OCC_PARTIAL: begin
                    if (push && !pop && count == CW'(DEPTH - 1)) begin
                        state <= OCC_FULL;
                    end else if (pop && !push && count == CW'(1)) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop && !push) state <= OCC_PARTIAL;
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_result_fifo.sv
// Self-checking bench for pipeline_result_fifo: fixed vector table, directed corner cases,
// then randomized traffic compared against a queue-based reference model.
module tb_pipeline_result_fifo;
    import pipeline_pkg::*;

    localparam int DEPTH = 16;
    localparam int AF_LEVEL = DEPTH - PIPE_AF_MARGIN;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [4:0]  count;
    logic        almost_full;
    logic        full;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] out_sum;

    int vectors;
    int miscompares;

    pipeline_result_fifo_if #(.DATA_WIDTH(32)) bus ();

    pipeline_result_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .AF_MARGIN  (PIPE_AF_MARGIN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .bus         (bus),
        .count       (count),
        .almost_full (almost_full),
        .full        (full),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .out_sum     (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue plus the statistics.
    stream_word_t model_q[$];
    stream_word_t model_sum;
    logic         model_ovf;
    int           model_drops;

    function automatic void model_reset();
        model_q.delete();
        model_sum   = '0;
        model_ovf   = 1'b0;
        model_drops = 0;
    endfunction

    function automatic void model_step();
        int   size_before;
        logic pop;
        size_before = model_q.size();
        pop = (size_before > 0) && bus.out_ready;
        if (clear) begin
            model_reset();
        end else begin
            if (pop) model_sum = model_sum + model_q.pop_front();
            if (bus.in_valid) begin
                if (size_before < DEPTH || pop) begin
                    model_q.push_back(bus.in_data);
                end else begin
                    model_ovf = 1'b1;
                    if (model_drops < 65535) model_drops++;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic rdy, input logic clr);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        clear         = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic checkOutput(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".count"},       32'(count),       32'(sz));
        chk({tag, ".out_valid"},   32'(bus.out_valid), 32'(sz != 0));
        chk({tag, ".out_data"},    bus.out_data,     (sz != 0) ? model_q[0] : 32'd0);
        chk({tag, ".full"},        32'(full),        32'(sz == DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AF_LEVEL));
        chk({tag, ".overflow"},    32'(overflow),    32'(model_ovf));
        chk({tag, ".drop_count"},  32'(drop_count),  32'(model_drops));
        chk({tag, ".out_sum"},     out_sum,          model_sum);
    endtask

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic [4:0]  exp_count;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();

        vecs[0] = '{1'b1, 32'h0000_00FD, 1'b0, 5'd1, 1'b1, 32'h0000_00FD, 32'h0000_0000};
        vecs[1] = '{1'b1, 32'h0000_0115, 1'b0, 5'd2, 1'b1, 32'h0000_00FD, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 5'd1, 1'b1, 32'h0000_0115, 32'h0000_00FD};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 32'h0000_0212};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0, 1'b0, 32'h0000_0000, 32'h0000_0212};

        reset_n       = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        checkOutput("reset");
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA3, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b1, 1'b0);
        checkOutput("pre_reset");
        bus.out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset.count",     32'(count),         32'd0);
        chk("async_reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_reset.overflow",  32'(overflow),      32'd0);
        chk("async_reset.out_sum",   out_sum,            32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset");

        $display("[TB] in-order delivery table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, 1'b0);
            chk($sformatf("vec%0d.count", i),     32'(count),         32'(vecs[i].exp_count));
            chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.out_data", i),  bus.out_data,       vecs[i].exp_data);
            chk($sformatf("vec%0d.out_sum", i),   out_sum,            vecs[i].exp_sum);
        end

        $display("[TB] fill to full and overflow");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            checkOutput("fill");
            if (i == 9)  chk("fill.af_at_10",   32'(almost_full), 32'd0);
            if (i == 10) chk("fill.af_at_11",   32'(almost_full), 32'd1);
            if (i == 14) chk("fill.full_at_15", 32'(full),        32'd0);
            if (i == 15) chk("fill.full_at_16", 32'(full),        32'd1);
        end
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("drop.count",      32'(count),      32'd16);
        chk("drop.overflow",   32'(overflow),   32'd1);
        chk("drop.drop_count", 32'(drop_count), 32'd1);

        $display("[TB] push and pop together while full");
        applyStimulus(1'b1, 32'hBEEF, 1'b1, 1'b0);
        chk("fullpp.count",      32'(count),      32'd16);
        chk("fullpp.drop_count", 32'(drop_count), 32'd1);
        chk("fullpp.out_data",   bus.out_data,    32'h101);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            checkOutput("drain");
            if (i == DEPTH - 2) chk("drain.tail_word", bus.out_data, 32'hBEEF);
        end

        $display("[TB] clear beats simultaneous push and pop");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        checkOutput("preclear");
        applyStimulus(1'b1, 32'hFFFF, 1'b1, 1'b1);
        chk("clear.count",      32'(count),         32'd0);
        chk("clear.out_valid",  32'(bus.out_valid), 32'd0);
        chk("clear.out_sum",    out_sum,            32'd0);
        chk("clear.overflow",   32'(overflow),      32'd0);
        chk("clear.drop_count", 32'(drop_count),    32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        chk("clear.discarded",  32'(count),         32'd0);

        $display("[TB] pointer wrap streaming");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
            checkOutput("stream");
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream.out_sum",    out_sum,         32'd780);
        chk("stream.drop_count", 32'(drop_count), 32'd0);
        chk("stream.count",      32'(count),      32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            int ready_pct;
            ready_pct = ((i / 60) % 2 == 0) ? 25 : 80;
            applyStimulus(($urandom_range(99) < 70),
                          $urandom,
                          ($urandom_range(99) < ready_pct),
                          ($urandom_range(199) == 0));
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
